// File: rtl/conv_mem_arbiter.sv
// conv_mem_arbiter: shares one layer-memory port among three requesters
// (0 = CONV writer, 1 = max-pool, 2 = host readback).
// Combinational one-hot grant per cycle (round-robin or fixed priority), optional
// bounded lock for read-modify-write bursts, registered memory strobes/address/data,
// and a two-stage read return tagged with the requester that issued the read.
// Ports:
//   clk, reset                    clock (posedge), synchronous active-high reset
//   req_valid/req_we/req_lock     per-requester request, write enable, lock hold
//   req_sel/req_addr/req_wdata    per-requester select (3b), address (12b), data (20b)
//   req_gnt                       one-hot combinational grant
//   rsp_valid/rsp_data            registered one-hot read-return valid and shared data
//   idle                          no request pending and no read in flight
//   cwr/crd/csel/caddr_wr/cdata_wr/caddr_rd   registered memory-side signals
//   cdata_rd                      memory read data, sampled the cycle crd is high
module conv_mem_arbiter #(
  parameter int unsigned RR_EN    = 1,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req_valid,
  input  logic [2:0]  req_we,
  input  logic [2:0]  req_lock,
  input  logic [8:0]  req_sel,
  input  logic [35:0] req_addr,
  input  logic [59:0] req_wdata,
  output logic [2:0]  req_gnt,
  output logic [2:0]  rsp_valid,
  output logic [19:0] rsp_data,
  output logic        idle,
  output logic        cwr,
  output logic        crd,
  output logic [2:0]  csel,
  output logic [11:0] caddr_wr,
  output logic [19:0] cdata_wr,
  output logic [11:0] caddr_rd,
  input  logic [19:0] cdata_rd
);

  localparam int unsigned NREQ   = 3;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 20;
  localparam int unsigned CNT_W  = 4;

  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              lock_act_q, lock_act_d;
  logic [IDX_W-1:0]  lock_own_q, lock_own_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic              cwr_q, cwr_d;
  logic              crd_q, crd_d;
  logic [SEL_W-1:0]  csel_q, csel_d;
  logic [ADDR_W-1:0] caddr_wr_q, caddr_wr_d;
  logic [DATA_W-1:0] cdata_wr_q, cdata_wr_d;
  logic [ADDR_W-1:0] caddr_rd_q, caddr_rd_d;
  logic [IDX_W-1:0]  rd_tag_q, rd_tag_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic [3:0]        valid_ext;
  logic              lock_hit_c;
  logic              gnt_any_c;
  logic [IDX_W-1:0]  gnt_idx_c;
  logic [SEL_W-1:0]  sel_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] wdata_c;
  logic              we_c;
  logic              lock_c;
  logic [CNT_W-1:0]  lock_inc_c;
  int unsigned       cand;

  // Pad to a power of two so a 2-bit index never selects outside the vector
  assign valid_ext  = {1'b0, req_valid};
  assign lock_hit_c = (RR_EN != 0) && lock_act_q && valid_ext[lock_own_q];

  // Grant selection: lock owner first, then rotating or fixed priority
  always_comb begin
    gnt_any_c = 1'b0;
    gnt_idx_c = '0;
    cand      = 0;
    if (lock_hit_c) begin
      gnt_any_c = 1'b1;
      gnt_idx_c = lock_own_q;
    end else if (RR_EN != 0) begin
      // Scan farthest-first so the candidate nearest rr_ptr overwrites last
      for (int unsigned k = 0; k < NREQ; k++) begin
        cand = (32'(rr_ptr_q) + (NREQ - 1 - k)) % NREQ;
        if (valid_ext[IDX_W'(cand)]) begin
          gnt_any_c = 1'b1;
          gnt_idx_c = IDX_W'(cand);
        end
      end
    end else begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (valid_ext[IDX_W'(NREQ - 1 - k)]) begin
          gnt_any_c = 1'b1;
          gnt_idx_c = IDX_W'(NREQ - 1 - k);
        end
      end
    end
    if (reset) begin
      gnt_any_c = 1'b0;
    end
  end

  assign req_gnt = gnt_any_c ? (3'b001 << gnt_idx_c) : 3'b000;

  // Payload of the granted requester
  always_comb begin
    sel_c   = req_sel[2:0];
    addr_c  = req_addr[11:0];
    wdata_c = req_wdata[19:0];
    we_c    = req_we[0];
    lock_c  = req_lock[0];
    case (gnt_idx_c)
      2'd1: begin
        sel_c   = req_sel[5:3];
        addr_c  = req_addr[23:12];
        wdata_c = req_wdata[39:20];
        we_c    = req_we[1];
        lock_c  = req_lock[1];
      end
      2'd2: begin
        sel_c   = req_sel[8:6];
        addr_c  = req_addr[35:24];
        wdata_c = req_wdata[59:40];
        we_c    = req_we[2];
        lock_c  = req_lock[2];
      end
      default: ;
    endcase
  end

  // Count continues only while the same owner keeps its lock
  assign lock_inc_c = ((lock_act_q && (lock_own_q == gnt_idx_c)) ? lock_cnt_q : '0)
                      + CNT_W'(1);

  // Next-state: arbitration pointer, lock, memory strobes and read pipeline
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    lock_act_d  = lock_act_q;
    lock_own_d  = lock_own_q;
    lock_cnt_d  = lock_cnt_q;
    cwr_d       = 1'b0;
    crd_d       = 1'b0;
    csel_d      = '0;
    caddr_wr_d  = caddr_wr_q;
    cdata_wr_d  = cdata_wr_q;
    caddr_rd_d  = caddr_rd_q;
    rd_tag_d    = rd_tag_q;
    rsp_valid_d = crd_q ? (3'b001 << rd_tag_q) : 3'b000;
    rsp_data_d  = crd_q ? cdata_rd : rsp_data_q;

    if (lock_act_q && !valid_ext[lock_own_q]) begin
      lock_act_d = 1'b0;
      lock_cnt_d = '0;
    end

    if (gnt_any_c) begin
      rr_ptr_d = (gnt_idx_c == IDX_W'(NREQ - 1)) ? '0 : gnt_idx_c + IDX_W'(1);
      csel_d   = sel_c;
      if (we_c) begin
        cwr_d      = 1'b1;
        caddr_wr_d = addr_c;
        cdata_wr_d = wdata_c;
      end else begin
        crd_d      = 1'b1;
        caddr_rd_d = addr_c;
        rd_tag_d   = gnt_idx_c;
      end
      if ((RR_EN != 0) && lock_c) begin
        // Forced release once the burst reaches its bound
        if (32'(lock_inc_c) >= LOCK_MAX) begin
          lock_act_d = 1'b0;
          lock_cnt_d = '0;
        end else begin
          lock_act_d = 1'b1;
          lock_own_d = gnt_idx_c;
          lock_cnt_d = lock_inc_c;
        end
      end else begin
        lock_act_d = 1'b0;
        lock_cnt_d = '0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      lock_act_q  <= 1'b0;
      lock_own_q  <= '0;
      lock_cnt_q  <= '0;
      cwr_q       <= 1'b0;
      crd_q       <= 1'b0;
      csel_q      <= '0;
      caddr_wr_q  <= '0;
      cdata_wr_q  <= '0;
      caddr_rd_q  <= '0;
      rd_tag_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      lock_act_q  <= lock_act_d;
      lock_own_q  <= lock_own_d;
      lock_cnt_q  <= lock_cnt_d;
      cwr_q       <= cwr_d;
      crd_q       <= crd_d;
      csel_q      <= csel_d;
      caddr_wr_q  <= caddr_wr_d;
      cdata_wr_q  <= cdata_wr_d;
      caddr_rd_q  <= caddr_rd_d;
      rd_tag_q    <= rd_tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cwr       = cwr_q;
  assign crd       = crd_q;
  assign csel      = csel_q;
  assign caddr_wr  = caddr_wr_q;
  assign cdata_wr  = cdata_wr_q;
  assign caddr_rd  = caddr_rd_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign idle      = ~|req_valid & ~crd_q & ~|rsp_valid_q;

endmodule
